// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: reset PC and NOP defaults,
// fetch state encoding and a PC increment helper.
package pipe_pkg;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_wdt.sv
// Instruction-memory wait watchdog: counts stalled request cycles
// and flags the cycle on which the LIMIT-th wait occurs (LIMIT=0 disables).
module fetch_wdt #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  // wait-cycle counter, cleared on response or state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

  // expiry does not look at clear, so the caller may derive clear from it
  assign expired = (LIMIT != 0) && tick && (count == LAST);

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC select, imem handshake, drain/hold/timeout.
// Optional PC_ALIGN_CHECK_EN: misaligned redirects set misalignF and stop in ERR.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR      = DEF_NOP_INSTR,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] instrF,
  output logic        validF,
  output logic        imem_errF,
  output logic        misalignF
);

  fetch_state_t state, state_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] kill_q, kill_n;
  logic [31:0] hold_q, hold_n;
  logic        err_q, err_n;
  logic        redir;
  logic        bad;
  logic        expired;
  logic        wdt_tick;
  logic        wdt_clear;

  assign redir = !stallF && PCSrcD;

`ifdef PC_ALIGN_CHECK_EN
  logic mis_q;

  assign bad = redir && (PCBranchD[1:0] != 2'b00);

  // sticky misaligned-redirect flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mis_q <= 1'b0;
    end else if (bad && state != ERR) begin
      mis_q <= 1'b1;
    end
  end

  assign misalignF = mis_q;
`else
  assign bad       = 1'b0;
  assign misalignF = 1'b0;
`endif

  // state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= FETCH;
      pc_q   <= RESET_PC;
      kill_q <= RESET_PC;
      hold_q <= NOP_INSTR;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      pc_q   <= pc_n;
      kill_q <= kill_n;
      hold_q <= hold_n;
      err_q  <= err_n;
    end
  end

  // next-state and next-PC selection
  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    kill_n  = kill_q;
    hold_n  = hold_q;
    err_n   = err_q;
    unique case (state)
      FETCH: begin
        if (bad) begin
          pc_n    = PCBranchD;
          state_n = ERR;
        end else if (redir) begin
          pc_n = PCBranchD;
          if (!imem_valid) begin
            kill_n  = pc_q;
            state_n = DRAIN;
          end
        end else if (imem_valid) begin
          if (stallF) begin
            hold_n  = imem_rdata;
            state_n = HOLD;
          end else begin
            pc_n = pc_plus4(pc_q);
          end
        end
        if (expired) begin
          state_n = ERR;
          err_n   = 1'b1;
        end
      end
      DRAIN: begin
        if (bad) begin
          pc_n    = PCBranchD;
          state_n = ERR;
        end else begin
          if (redir) pc_n = PCBranchD;
          if (imem_valid) state_n = FETCH;
        end
        if (expired) begin
          state_n = ERR;
          err_n   = 1'b1;
        end
      end
      HOLD: begin
        if (bad) begin
          pc_n    = PCBranchD;
          state_n = ERR;
        end else if (!stallF) begin
          pc_n    = PCSrcD ? PCBranchD : pc_plus4(pc_q);
          state_n = FETCH;
        end
      end
      ERR: begin
        state_n = ERR;
      end
    endcase
  end

  // handshake and IF/ID outputs
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    validF    = 1'b0;
    instrF    = NOP_INSTR;
    if (!reset) begin
      unique case (state)
        FETCH: begin
          imem_req = 1'b1;
          validF   = !stallF && !PCSrcD && imem_valid;
          instrF   = validF ? imem_rdata : NOP_INSTR;
        end
        DRAIN: begin
          imem_req  = 1'b1;
          imem_addr = kill_q;
        end
        HOLD: begin
          validF = !stallF && !PCSrcD;
          instrF = validF ? hold_q : NOP_INSTR;
        end
        ERR: begin
          imem_req = 1'b0;
        end
      endcase
    end
  end

  assign wdt_tick  = imem_req && !imem_valid;
  assign wdt_clear = imem_valid || (state_n != state);

  fetch_wdt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wdt (
    .clk    (clk),
    .reset  (reset),
    .clear  (wdt_clear),
    .tick   (wdt_tick),
    .expired(expired)
  );

  assign PCF       = pc_q;
  assign PCPlus4F  = pc_plus4(pc_q);
  assign imem_errF = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable imem model.
// Expected values are hand-derived from the PC sequence of each scenario.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF;
  logic        PCSrcD;
  logic [31:0] PCBranchD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic [31:0] instrF;
  logic        validF;
  logic        imem_errF;
  logic        misalignF;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int wcnt   = 0;
  bit mem_on = 1'b1;

  fetch_stage #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stallF    (stallF),
    .PCSrcD    (PCSrcD),
    .PCBranchD (PCBranchD),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_valid(imem_valid),
    .imem_rdata(imem_rdata),
    .PCF       (PCF),
    .PCPlus4F  (PCPlus4F),
    .instrF    (instrF),
    .validF    (validF),
    .imem_errF (imem_errF),
    .misalignF (misalignF)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'hA5A5_0000 ^ a;
  endfunction

  // memory answers on the lat-th cycle a request is held
  always_comb imem_rdata = memw(imem_addr);
  always_comb imem_valid = mem_on && imem_req && (wcnt + 1 >= lat);

  always @(posedge clk) begin
    wcnt <= (imem_req && !imem_valid) ? wcnt + 1 : 0;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic p, input logic [31:0] t);
    @(posedge clk);
    #1;
    stallF    = s;
    PCSrcD    = p;
    PCBranchD = t;
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    stallF = 1'b0;
    PCSrcD = 1'b0;
    reset  = 1'b0;
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    stallF    = 1'b0;
    PCSrcD    = 1'b0;
    PCBranchD = 32'h0;
    #12;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(validF), 0);
    chk("rst_instr", instrF, 32'h0);
    chk("rst_pc", PCF, 32'h0);
    chk("rst_pc4", PCPlus4F, 32'h4);
    chk("rst_err", 32'(imem_errF), 0);
    chk("rst_mis", 32'(misalignF), 0);
    reset = 1'b0;
    #1;

    // zero-wait streaming
    for (int i = 0; i < 4; i++) begin
      if (i != 0) cyc(1'b0, 1'b0, 32'h0);
      chk("zw_pc", PCF, 32'(4 * i));
      chk("zw_valid", 32'(validF), 1);
      chk("zw_instr", instrF, memw(32'(4 * i)));
    end

    // two-cycle latency
    cyc(1'b0, 1'b0, 32'h0);
    lat = 2;
    #1;
    for (int f = 0; f < 2; f++) begin
      for (int w = 0; w < 2; w++) begin
        if (f != 0 || w != 0) cyc(1'b0, 1'b0, 32'h0);
        chk("l2_addr", imem_addr, 32'(16 + 4 * f));
        chk("l2_pc", PCF, 32'(16 + 4 * f));
        chk("l2_valid", 32'(validF), 32'(w));
      end
    end
    chk("l2_instr", instrF, memw(32'h14));

    // response under stall goes to HOLD, delivered once on release
    cyc(1'b0, 1'b0, 32'h0);
    chk("hd_wait_valid", 32'(validF), 0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("hd_resp_req", 32'(imem_req), 1);
    chk("hd_resp_valid", 32'(validF), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 32'h0);
      chk("hd_req", 32'(imem_req), 0);
      chk("hd_valid", 32'(validF), 0);
      chk("hd_pc", PCF, 32'h18);
    end
    cyc(1'b0, 1'b0, 32'h0);
    chk("hd_rel_valid", 32'(validF), 1);
    chk("hd_rel_instr", instrF, memw(32'h18));
    cyc(1'b0, 1'b0, 32'h0);
    chk("hd_next_pc", PCF, 32'h1C);
    chk("hd_next_req", 32'(imem_req), 1);
    chk("hd_next_valid", 32'(validF), 0);

    // redirect while request outstanding drains old response
    lat = 1;
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0);
    chk("dr_pre_pc", PCF, 32'hC);
    cyc(1'b0, 1'b1, 32'h40);
    lat = 3;
    #1;
    chk("dr0_addr", imem_addr, 32'h10);
    chk("dr0_valid", 32'(validF), 0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("dr1_addr", imem_addr, 32'h10);
    chk("dr1_pc", PCF, 32'h40);
    chk("dr1_valid", 32'(validF), 0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("dr2_addr", imem_addr, 32'h10);
    chk("dr2_mem", 32'(imem_valid), 1);
    chk("dr2_valid", 32'(validF), 0);
    chk("dr2_instr", instrF, 32'h0);
    lat = 1;
    cyc(1'b0, 1'b0, 32'h0);
    chk("dr3_addr", imem_addr, 32'h40);
    chk("dr3_valid", 32'(validF), 1);
    chk("dr3_instr", instrF, memw(32'h40));
    cyc(1'b0, 1'b1, 32'h80);
    chk("rz_valid", 32'(validF), 0);
    chk("rz_instr", instrF, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("rz_pc", PCF, 32'h80);
    chk("rz_instr2", instrF, memw(32'h80));

    // timeout after 8 wait cycles
    mem_on = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i != 0) cyc(1'b0, 1'b0, 32'h0);
      chk("to_req", 32'(imem_req), 1);
      chk("to_err", 32'(imem_errF), 0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 32'h0);
      chk("to_err_req", 32'(imem_req), 0);
      chk("to_err_flag", 32'(imem_errF), 1);
      chk("to_err_valid", 32'(validF), 0);
    end
    mem_on = 1'b1;
    do_reset();
    chk("to_rst_err", 32'(imem_errF), 0);
    chk("to_rst_pc", PCF, 32'h0);
    chk("to_rst_valid", 32'(validF), 1);
    chk("to_rst_instr", instrF, memw(32'h0));

    // misaligned redirect target
    cyc(1'b0, 1'b1, 32'h42);
    chk("ma_valid", 32'(validF), 0);
    cyc(1'b0, 1'b0, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
    chk("ma_flag", 32'(misalignF), 1);
    chk("ma_req", 32'(imem_req), 0);
`else
    chk("ma_flag", 32'(misalignF), 0);
    chk("ma_addr", imem_addr, 32'h42);
    chk("ma_req", 32'(imem_req), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
